fpu_uart_sequencer: RTL and testbench
=====================================

# fpu_uart_sequencer

Byte-level controller between the UART receiver/transmitter and the single-precision FPU cores (add, mul, div). It assembles a 9-byte command frame (operand A, operand B, opcode), issues exactly one validated request to the selected FPU core, and waits for that core's ready. It then captures the 32-bit result and streams it back as 4 bytes under the transmitter's busy handshake. It replaces free-running operand registers with an explicit, single-outstanding-operation sequence.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1024, maximum cycles in WAIT before abort; 16-bit counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe; rx_data valid this cycle.
- tx_data  out  8  byte to transmit; held from tx_start until the next tx_start.
- tx_start  out  1  one-cycle pulse requesting transmission of tx_data.
- tx_busy  in  1  transmitter busy.
- op_a  out  32  operand A to FPU cores.
- op_b  out  32  operand B to FPU cores (sign-adjusted for SUB).
- op_sel  out  2  00 add, 01 sub, 10 mul, 11 div; selects dval target and rdy/result source.
- fpu_dval  out  1  one-cycle start pulse to the selected core.
- fpu_result  in  32  result from the selected core.
- fpu_rdy  in  1  ready from the selected core.
- busy  out  1  high in every state except COLLECT.
- err  out  1  one-cycle pulse on bad opcode or timeout.
- overrun  out  1  one-cycle pulse when an rx byte is dropped.

## Operation
- Frame: bytes 0–3 are op_a[31:24]..[7:0], bytes 4–7 are op_b big-endian, byte 8 is the opcode. Opcodes: 0xF0 ADD, 0x0F SUB, 0x33 MUL, 0xCC DIV.
- States: COLLECT → DECODE → ISSUE → WAIT → SEND → SEND_WAIT → (SEND | COLLECT).
- COLLECT: each rx_valid writes the byte at index cnt (4-bit, 0..8) and increments cnt. When the byte at cnt==8 is accepted, go to DECODE and clear cnt.
- DECODE: on a valid opcode, set op_sel. For SUB, invert op_b[31]; for the others, op_b equals the received bytes. Go to ISSUE. On an invalid opcode, load result register with 0xFFFFFFFF, pulse err, and go to SEND.
- ISSUE: fpu_dval=1 for exactly this cycle; go to WAIT and clear the timeout counter.
- WAIT: when fpu_rdy=1, capture fpu_result into the result register and go to SEND. fpu_rdy is ignored in all other states.
- SEND: when tx_busy=0, drive tx_data = result byte k (k=0 is [31:24]), pulse tx_start, and go to SEND_WAIT.
- SEND_WAIT: ignore tx_busy in the first cycle. Afterwards, on the first cycle with tx_busy=0: increment k; go to SEND if k<4, otherwise go to COLLECT.
- rx_valid outside COLLECT: byte dropped, overrun pulses, cnt unchanged.
- op_a, op_b, and op_sel are held stable from DECODE until the exit from WAIT.

## Timing
- Reset values: tx_data=0x00, tx_start=0, op_a=0, op_b=0, op_sel=00, fpu_dval=0, busy=0, err=0, overrun=0. State=COLLECT, cnt=0, k=0, result=0.
- Opcode byte accepted in cycle N: DECODE at N+1, fpu_dval at N+2.
- fpu_rdy sampled high in cycle M: result registered at M, first tx_start at M+1 if tx_busy=0.
- Minimum spacing between tx_start pulses: 2 cycles.
- rst_n assertion in any state (including mid-SEND) forces the reset values immediately. Partial frames are discarded and no tx_start occurs until a new complete frame arrives.
- fpu_rdy and rx_valid arriving in the same WAIT cycle: the result is captured and the byte is dropped (overrun pulses).

## Configuration
- FPU_SEQ_TIMEOUT_EN defined: if WAIT persists for TIMEOUT_CYCLES cycles without fpu_rdy, load result=0x7FC00000 (qNaN), pulse err, and go to SEND. A late fpu_rdy is ignored.
- FPU_SEQ_TIMEOUT_EN undefined: no counter; WAIT is held indefinitely until fpu_rdy or reset.

## Test plan
- ADD: frame 3F C0 00 00 40 10 00 00 F0, core model returns 0x40700000 after 5 cycles → fpu_dval single pulse with op_sel=00; tx bytes 40 70 00 00 in order; busy drops after the last byte.
- SUB: frame 40 10 00 00 3F C0 00 00 0F → op_b=0xBFC00000, op_sel=01; model returns 0x3F400000 → tx 3F 40 00 00.
- DIV with tx_busy held high for 10 cycles after each tx_start: frame 40 C0 00 00 40 00 00 00 CC, rdy after 20 cycles → tx 40 40 00 00; no tx_start while tx_busy=1.
- Bad opcode 0x55 → no fpu_dval; err pulses once; tx FF FF FF FF. A byte sent during SEND → overrun pulses and the next frame decodes correctly.
- Timeout (macro on, TIMEOUT_CYCLES=16): fpu_rdy never asserted → err at ISSUE+16; tx 7F C0 00 00; an rdy pulse injected afterwards is ignored.
- Reset mid-SEND after 2 bytes → outputs return to reset values, no further tx_start; a following full MUL frame 40 00 00 00 40 40 00 00 33 with result 0x40C00000 → tx 40 C0 00 00.

Source files
------------

// File: rtl/fpu_uart_sequencer.sv
// fpu_uart_sequencer: byte-level sequencer between the UART and the FPU cores.
// It collects a 9-byte frame (op A, op B, opcode), issues one request to the
// selected core and waits for its ready. The 32-bit result goes back MSB first
// as 4 bytes, paced by the transmitter's busy handshake.
// Optional build macro FPU_SEQ_TIMEOUT_EN: abort WAIT after TIMEOUT_CYCLES
// cycles, returning qNaN and pulsing err.
module fpu_uart_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic [1:0]  op_sel,
  output logic        fpu_dval,
  input  logic [31:0] fpu_result,
  input  logic        fpu_rdy,
  output logic        busy,
  output logic        err,
  output logic        overrun
);

  localparam logic [2:0] S_COLLECT   = 3'd0;
  localparam logic [2:0] S_DECODE    = 3'd1;
  localparam logic [2:0] S_ISSUE     = 3'd2;
  localparam logic [2:0] S_WAIT      = 3'd3;
  localparam logic [2:0] S_SEND      = 3'd4;
  localparam logic [2:0] S_SEND_WAIT = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  k_q, k_d;
  logic        first_q, first_d;
  logic [31:0] res_q, res_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic [7:0]  opc_q, opc_d;
  logic [1:0]  sel_q, sel_d;
  logic [7:0]  txd_q, txd_d;
`ifdef FPU_SEQ_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_q, tmo_d;
`endif

  logic       opc_ok;
  logic [1:0] opc_sel;
  logic [7:0] res_byte;

  // Opcode byte to core select; anything else is a bad frame.
  always_comb begin
    opc_ok  = 1'b1;
    opc_sel = 2'b00;
    case (opc_q)
      8'hF0:   opc_sel = 2'b00;
      8'h0F:   opc_sel = 2'b01;
      8'h33:   opc_sel = 2'b10;
      8'hCC:   opc_sel = 2'b11;
      default: opc_ok  = 1'b0;
    endcase
  end

  // Result byte k, MSB first.
  always_comb begin
    case (k_q)
      2'd0:    res_byte = res_q[31:24];
      2'd1:    res_byte = res_q[23:16];
      2'd2:    res_byte = res_q[15:8];
      default: res_byte = res_q[7:0];
    endcase
  end

  assign op_a    = opa_q;
  assign op_b    = opb_q;
  assign op_sel  = sel_q;
  assign busy    = (state_q != S_COLLECT);
  assign overrun = rx_valid && (state_q != S_COLLECT);

  // Next-state logic; strobes are decoded from state so they land in the
  // same cycle as the condition that fires them.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    k_d      = k_q;
    first_d  = first_q;
    res_d    = res_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    opc_d    = opc_q;
    sel_d    = sel_q;
    txd_d    = txd_q;
`ifdef FPU_SEQ_TIMEOUT_EN
    tmo_d    = tmo_q;
`endif
    tx_start = 1'b0;
    fpu_dval = 1'b0;
    err      = 1'b0;
    case (state_q)
      S_COLLECT: if (rx_valid) begin
        // Bytes arrive MSB first, so shifting in builds each operand.
        if (cnt_q < 4'd4)      opa_d = {opa_q[23:0], rx_data};
        else if (cnt_q < 4'd8) opb_d = {opb_q[23:0], rx_data};
        if (cnt_q == 4'd8) begin
          opc_d   = rx_data;
          cnt_d   = 4'd0;
          state_d = S_DECODE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DECODE: begin
        if (opc_ok) begin
          sel_d = opc_sel;
          if (opc_sel == 2'b01) opb_d[31] = ~opb_q[31];
          state_d = S_ISSUE;
        end else begin
          res_d   = 32'hFFFF_FFFF;
          err     = 1'b1;
          state_d = S_SEND;
        end
      end
      S_ISSUE: begin
        fpu_dval = 1'b1;
`ifdef FPU_SEQ_TIMEOUT_EN
        tmo_d    = 16'd0;
`endif
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        if (fpu_rdy) begin
          res_d   = fpu_result;
          state_d = S_SEND;
        end
`ifdef FPU_SEQ_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          res_d   = 32'h7FC0_0000;
          err     = 1'b1;
          state_d = S_SEND;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
`endif
      end
      S_SEND: if (!tx_busy) begin
        tx_start = 1'b1;
        txd_d    = res_byte;
        first_d  = 1'b1;
        state_d  = S_SEND_WAIT;
      end
      S_SEND_WAIT: begin
        // The transmitter may not raise busy until a cycle after tx_start.
        if (first_q) begin
          first_d = 1'b0;
        end else if (!tx_busy) begin
          k_d     = k_q + 2'd1;
          state_d = (k_q == 2'd3) ? S_COLLECT : S_SEND;
        end
      end
      default: state_d = S_COLLECT;
    endcase
    tx_data = tx_start ? res_byte : txd_q;
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_COLLECT;
      cnt_q   <= 4'd0;
      k_q     <= 2'd0;
      first_q <= 1'b0;
      res_q   <= 32'd0;
      opa_q   <= 32'd0;
      opb_q   <= 32'd0;
      opc_q   <= 8'd0;
      sel_q   <= 2'b00;
      txd_q   <= 8'd0;
`ifdef FPU_SEQ_TIMEOUT_EN
      tmo_q   <= 16'd0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      first_q <= first_d;
      res_q   <= res_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      opc_q   <= opc_d;
      sel_q   <= sel_d;
      txd_q   <= txd_d;
`ifdef FPU_SEQ_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

endmodule

// File: tb/tb_fpu_uart_sequencer.sv
// Bench for fpu_uart_sequencer: directed frames from the test plan plus random
// frames, checked against a frame-level reference of expected core request,
// tx byte stream, err and overrun counts.
module tb_fpu_uart_sequencer;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [7:0]  rx_data = 8'd0, tx_data;
  logic        rx_valid = 1'b0, tx_start, tx_busy = 1'b0;
  logic [31:0] op_a, op_b, fpu_result = 32'd0;
  logic [1:0]  op_sel;
  logic        fpu_dval, rdy_m = 1'b0, inj_rdy = 1'b0, fpu_rdy_w;
  logic        busy, err, overrun;

  assign fpu_rdy_w = rdy_m | inj_rdy;

  fpu_uart_sequencer #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .op_a(op_a), .op_b(op_b), .op_sel(op_sel), .fpu_dval(fpu_dval),
    .fpu_result(fpu_result), .fpu_rdy(fpu_rdy_w),
    .busy(busy), .err(err), .overrun(overrun));

  always #5 clk = ~clk;

`ifdef FPU_SEQ_TIMEOUT_EN
  localparam int DIV_LAT = 12;
`else
  localparam int DIV_LAT = 20;
`endif

  int n_chk = 0, n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Expected frame outcome and environment knobs (written by the main thread only).
  logic [31:0] exp_a, exp_b, exp_res, model_res;
  logic [1:0]  exp_sel;
  bit          exp_ok, model_en = 1'b1;
  int          model_lat = 1, busy_len = 0;

  // Observations (written by the monitor only).
  logic [7:0] txq[$];
  logic [7:0] last_tx = 8'd0;
  int n_dval = 0, n_errp = 0, n_ovr = 0, n_starts = 0;
  int last_start = -100, dval_cyc = 0, err_cyc = 0;

  // Monitor: sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_tx = 8'd0;
    end else begin
      if (tx_start) begin
        txq.push_back(tx_data);
        chk("tx_start_while_busy", {31'd0, tx_busy}, 32'd0);
        chk("tx_start_gap", {31'd0, (cyc - last_start) >= 2}, 32'd1);
        last_start = cyc;
        last_tx    = tx_data;
        n_starts++;
      end else begin
        chk("tx_data_hold", {24'd0, tx_data}, {24'd0, last_tx});
      end
      if (err) begin n_errp++; err_cyc = cyc; end
      if (overrun) n_ovr++;
      if (fpu_dval) begin
        n_dval++;
        dval_cyc = cyc;
        chk("dval_op_a", op_a, exp_a);
        chk("dval_op_b", op_b, exp_b);
        chk("dval_op_sel", {30'd0, op_sel}, {30'd0, exp_sel});
      end
      if (rdy_m) begin
        chk("rdy_op_a_held", op_a, exp_a);
        chk("rdy_op_b_held", op_b, exp_b);
        chk("rdy_op_sel_held", {30'd0, op_sel}, {30'd0, exp_sel});
      end
    end
  end

  // Transmitter model: busy for busy_len cycles after each tx_start.
  int seen_starts = 0, busy_left = 0;
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      busy_left   = 0;
      seen_starts = n_starts;
      tx_busy     = 1'b0;
    end else begin
      if (n_starts != seen_starts) begin
        seen_starts = n_starts;
        busy_left   = busy_len;
      end
      tx_busy = (busy_left > 0);
      if (busy_left > 0) busy_left--;
    end
  end

  // FPU core model: one rdy pulse model_lat cycles after dval.
  always begin
    @(negedge clk);
    if (rst_n && fpu_dval && model_en) begin
      repeat (model_lat) @(posedge clk);
      #1;
      fpu_result = model_res;
      rdy_m      = 1'b1;
      @(posedge clk);
      #1;
      rdy_m      = 1'b0;
      fpu_result = $urandom;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic rx_put(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  // Reference: what a frame must produce, from the frame bytes alone.
  task automatic prep_frame(input logic [7:0] f[9], input logic [31:0] res,
                            input int lat, input int blen);
    exp_a   = {f[0], f[1], f[2], f[3]};
    exp_b   = {f[4], f[5], f[6], f[7]};
    exp_ok  = 1'b1;
    exp_sel = 2'd0;
    case (f[8])
      8'hF0: exp_sel = 2'd0;
      8'h0F: begin exp_sel = 2'd1; exp_b = exp_b ^ 32'h8000_0000; end
      8'h33: exp_sel = 2'd2;
      8'hCC: exp_sel = 2'd3;
      default: exp_ok = 1'b0;
    endcase
    exp_res   = exp_ok ? res : 32'hFFFF_FFFF;
    model_res = res;
    model_lat = lat;
    busy_len  = blen;
    txq.delete();
  endtask

  task automatic send_bytes(input logic [7:0] f[9]);
    for (int i = 0; i < 9; i++) begin
      idle($urandom_range(0, 2));
      rx_put(f[i]);
    end
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      if (txq.size() >= 4 && !busy) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic check_tx(input string tag, input logic [31:0] want);
    chk({tag, "_tx_count"}, txq.size(), 32'd4);
    for (int k = 0; k < 4; k++)
      chk({tag, "_tx_byte"}, (k < txq.size()) ? {24'd0, txq[k]} : 32'hDEAD,
          {24'd0, want[31-8*k -: 8]});
  endtask

  // stray: 0 none, 1 random, 2 all three cycles after the opcode byte.
  task automatic run_frame(input string tag, input logic [7:0] f[9], input logic [31:0] res,
                           input int lat, input int blen, input int stray);
    int d0, e0, o0, ns;
    bit ok;
    prep_frame(f, res, lat, blen);
    d0 = n_dval; e0 = n_errp; o0 = n_ovr; ns = 0;
    send_bytes(f);
    // The three cycles after the opcode byte are always DECODE/ISSUE/WAIT or SEND.
    for (int j = 0; j < 3; j++) begin
      if (stray == 2 || (stray == 1 && $urandom_range(0, 1) == 1)) begin
        rx_data = 8'($urandom); rx_valid = 1'b1; ns++;
      end
      @(posedge clk); #1;
      rx_valid = 1'b0;
    end
    wait_done(ok);
    chk({tag, "_done"}, {31'd0, ok}, 32'd1);
    check_tx(tag, exp_res);
    chk({tag, "_dval_count"}, n_dval - d0, exp_ok ? 32'd1 : 32'd0);
    chk({tag, "_err_count"}, n_errp - e0, exp_ok ? 32'd0 : 32'd1);
    chk({tag, "_overrun_count"}, n_ovr - o0, ns);
    chk({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_tx_data"}, {24'd0, tx_data}, 32'd0);
    chk({tag, "_tx_start"}, {31'd0, tx_start}, 32'd0);
    chk({tag, "_op_a"}, op_a, 32'd0);
    chk({tag, "_op_b"}, op_b, 32'd0);
    chk({tag, "_op_sel"}, {30'd0, op_sel}, 32'd0);
    chk({tag, "_fpu_dval"}, {31'd0, fpu_dval}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
    chk({tag, "_overrun"}, {31'd0, overrun}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish (n_chk=%0d)", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] f[9];
    logic [7:0] opc;
    int r, s0, e0;
    bit ok;

    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    f = '{8'h3F, 8'hC0, 8'h00, 8'h00, 8'h40, 8'h10, 8'h00, 8'h00, 8'hF0};
    run_frame("add", f, 32'h4070_0000, 5, 0, 0);
    f = '{8'h40, 8'h10, 8'h00, 8'h00, 8'h3F, 8'hC0, 8'h00, 8'h00, 8'h0F};
    run_frame("sub", f, 32'h3F40_0000, 3, 1, 0);
    f = '{8'h40, 8'hC0, 8'h00, 8'h00, 8'h40, 8'h00, 8'h00, 8'h00, 8'hCC};
    run_frame("div", f, 32'h4040_0000, DIV_LAT, 10, 0);
    f = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h55};
    run_frame("badop", f, 32'h0, 3, 2, 2);
    // rdy on the first WAIT cycle together with a dropped rx byte
    f = '{8'h3F, 8'h80, 8'h00, 8'h00, 8'h3F, 8'h80, 8'h00, 8'h00, 8'hF0};
    run_frame("rdy_rx_same", f, 32'h4000_0000, 1, 0, 2);

    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < 8; i++) f[i] = 8'($urandom);
      r = $urandom_range(0, 4);
      case (r)
        0: opc = 8'hF0;
        1: opc = 8'h0F;
        2: opc = 8'h33;
        3: opc = 8'hCC;
        default: begin
          opc = 8'($urandom);
          while (opc == 8'hF0 || opc == 8'h0F || opc == 8'h33 || opc == 8'hCC) opc = 8'($urandom);
        end
      endcase
      f[8] = opc;
      run_frame("rand", f, $urandom, $urandom_range(1, 12), $urandom_range(0, 4), 1);
    end

    // Reset after two bytes of the result have gone out.
    f = '{8'h3F, 8'hC0, 8'h00, 8'h00, 8'h40, 8'h10, 8'h00, 8'h00, 8'hF0};
    prep_frame(f, 32'h4070_0000, 3, 8);
    send_bytes(f);
    ok = 1'b0;
    for (int t = 0; t < 500; t++) begin
      if (txq.size() >= 2) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    chk("midsend_reached", {31'd0, ok}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midsend_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    s0 = n_starts;
    idle(30);
    chk("no_tx_after_rst", n_starts - s0, 32'd0);
    // Partial frame then reset: it must be discarded.
    for (int i = 0; i < 4; i++) rx_put(8'hA5);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    idle(1);
    f = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h40, 8'h40, 8'h00, 8'h00, 8'h33};
    run_frame("mul_after_rst", f, 32'h40C0_0000, 4, 1, 0);

`ifdef FPU_SEQ_TIMEOUT_EN
    // Core never answers: qNaN after 16 WAIT cycles, late rdy ignored.
    f = '{8'h3F, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hCC};
    prep_frame(f, 32'h7FC0_0000, 1, 2);
    model_en = 1'b0;
    e0 = n_errp;
    send_bytes(f);
    ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      if (n_errp != e0) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    chk("tmo_err_seen", {31'd0, ok}, 32'd1);
    chk("tmo_latency", err_cyc - dval_cyc, 32'd16);
    inj_rdy = 1'b1;
    @(posedge clk); #1;
    inj_rdy = 1'b0;
    wait_done(ok);
    chk("tmo_done", {31'd0, ok}, 32'd1);
    check_tx("tmo", 32'h7FC0_0000);
    chk("tmo_err_count", n_errp - e0, 32'd1);
    model_en = 1'b1;
`else
    // No timeout: a very slow core is still waited for.
    f = '{8'h3F, 8'h80, 8'h00, 8'h00, 8'h3F, 8'h80, 8'h00, 8'h00, 8'h33};
    run_frame("slow_core", f, 32'h3F80_0000, 150, 0, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
